// File: rtl/display_scan_ctrl_if.sv
// Load/ack handshake between the digit-value producer and the scan controller.
// The master drives din/load; the controller answers with load_ack/pending.
interface display_scan_ctrl_if;
  logic [15:0] din;
  logic        load;
  logic        load_ack;
  logic        pending;

  modport master (output din, output load, input load_ack, input pending);
  modport slave  (input din, input load, output load_ack, output pending);
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit display scan controller: a prescaler paces the digit rotation with a
// blanking gap per slot, and shadowed digit values commit only at the frame wrap.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_DRIVE | Select = one-hot(index); a tick advances the index and starts blanking
// ST_BLANK | Select dark; counts down BLANK cycles, then drives the new index
module display_scan_ctrl #(
  parameter int PRESCALE = 100000,
  parameter int BLANK    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  display_scan_ctrl_if.slave   bus,
  output logic [3:0]           displayA,
  output logic [3:0]           displayB,
  output logic [3:0]           displayC,
  output logic [3:0]           displayD,
  output logic [3:0]           Select,
  output logic                 frame_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BLANK_INIT = (BLANK > 0) ? BW'(BLANK - 1) : '0;

  localparam logic [0:0] ST_DRIVE = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [0:0]    state_q, state_d;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  logic [3:0]    select_q, select_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          frame_start_q, frame_start_d;
  logic          load_ack_q, load_ack_d;

  logic tick;
  logic wrap;
  logic commit;

  function automatic logic [3:0] one_hot(input logic [1:0] i);
    one_hot = 4'b0001 << i;
  endfunction

  always_comb begin
    presc_d       = presc_q;
    idx_d         = idx_q;
    state_d       = state_q;
    blank_cnt_d   = blank_cnt_q;
    select_d      = select_q;
    disp_d        = disp_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;

    tick   = en && (presc_q == PRESC_MAX);
    wrap   = tick && (idx_q == 2'd3);
    commit = wrap && pending_q;

    if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
    if (tick) begin
      idx_d = idx_q + 2'd1;
    end

    // Disabling blanks immediately but leaves state/index/blank count parked.
    if (!en) begin
      select_d = '0;
    end else begin
      case (state_q)
        ST_DRIVE: begin
          if (tick) begin
            if (BLANK == 0) begin
              select_d = one_hot(idx_q + 2'd1);
            end else begin
              state_d     = ST_BLANK;
              blank_cnt_d = BLANK_INIT;
              select_d    = '0;
            end
          end else begin
            select_d = one_hot(idx_q);
          end
        end
        ST_BLANK: begin
          if (blank_cnt_q == '0) begin
            state_d  = ST_DRIVE;
            select_d = one_hot(idx_q);
          end else begin
            blank_cnt_d = blank_cnt_q - 1'b1;
            select_d    = '0;
          end
        end
        default: begin
          state_d  = ST_DRIVE;
          select_d = '0;
        end
      endcase
    end

    // Commit reads the old shadow, so a load in the same cycle stays pending.
    if (commit) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (bus.load) begin
      shadow_d  = bus.din;
      pending_d = 1'b1;
    end

    frame_start_d = wrap;
    load_ack_d    = commit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q       <= '0;
      idx_q         <= '0;
      state_q       <= ST_DRIVE;
      blank_cnt_q   <= '0;
      select_q      <= 4'b0001;
      disp_q        <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      load_ack_q    <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      state_q       <= state_d;
      blank_cnt_q   <= blank_cnt_d;
      select_q      <= select_d;
      disp_q        <= disp_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      load_ack_q    <= load_ack_d;
    end
  end

  assign displayA     = disp_q[3:0];
  assign displayB     = disp_q[7:4];
  assign displayC     = disp_q[11:8];
  assign displayD     = disp_q[15:12];
  assign Select       = select_q;
  assign frame_start  = frame_start_q;
  assign bus.load_ack = load_ack_q;
  assign bus.pending  = pending_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with PRESCALE=4, BLANK=1 (16-cycle frame).
// cyc counts enabled clock edges since reset release; slot = cyc/4, dark when cyc%4==0.
module tb_display_scan_ctrl;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] displayA, displayB, displayC, displayD;
  logic [3:0] Select;
  logic       frame_start;

  int n_checks;
  int n_fail;
  int cyc;

  display_scan_ctrl_if bus();

  display_scan_ctrl #(.PRESCALE(4), .BLANK(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .bus        (bus),
    .displayA   (displayA),
    .displayB   (displayB),
    .displayC   (displayC),
    .displayD   (displayD),
    .Select     (Select),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    if (en) cyc++;
    #1;
  endtask

  task automatic run_to(input int c);
    for (int g = 0; g < 1000 && cyc < c; g++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; bus.load = 1'b0; bus.din = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (Select !== 4'b0001) begin n_fail++; $display("FAIL reset_select got=%b exp=0001", Select); end
    n_checks++;
    if ({displayD, displayC, displayB, displayA} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_display got=%h exp=0000", {displayD, displayC, displayB, displayA});
    end
    n_checks++;
    if ({bus.pending, bus.load_ack, frame_start} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000", {bus.pending, bus.load_ack, frame_start});
    end
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_scan();
    logic [3:0] exp_sel;
    logic       exp_fs;
    for (int k = 1; k <= 32; k++) begin
      step();
      exp_sel = ((cyc % 4) == 0) ? 4'b0000 : (4'b0001 << ((cyc / 4) % 4));
      exp_fs  = ((cyc % 16) == 0);
      n_checks++;
      if (Select !== exp_sel) begin n_fail++; $display("FAIL scan_select cyc=%0d got=%b exp=%b", cyc, Select, exp_sel); end
      n_checks++;
      if (frame_start !== exp_fs) begin n_fail++; $display("FAIL scan_frame_start cyc=%0d got=%b exp=%b", cyc, frame_start, exp_fs); end
    end
  endtask

  task automatic test_load_commit();
    run_to(37);
    bus.din = 16'h4321; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    n_checks++;
    if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL lc_pending got=%b exp=1", bus.pending); end
    run_to(47);
    n_checks++;
    if ({displayD, displayC, displayB, displayA, bus.load_ack} !== {16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL lc_before_wrap disp=%h ack=%b exp=0000/0", {displayD, displayC, displayB, displayA}, bus.load_ack);
    end
    step();
    n_checks++;
    if ({displayD, displayC, displayB, displayA} !== 16'h4321) begin
      n_fail++; $display("FAIL lc_commit disp=%h exp=4321", {displayD, displayC, displayB, displayA});
    end
    n_checks++;
    if ({bus.load_ack, frame_start, bus.pending} !== 3'b110) begin
      n_fail++; $display("FAIL lc_commit_flags ack/fs/pend got=%b exp=110", {bus.load_ack, frame_start, bus.pending});
    end
    step();
    n_checks++;
    if ({bus.load_ack, frame_start} !== 2'b00) begin
      n_fail++; $display("FAIL lc_pulse_width got=%b exp=00", {bus.load_ack, frame_start});
    end
  endtask

  task automatic test_overwrite();
    int acks;
    acks = 0;
    run_to(50);
    bus.din = 16'hAAAA; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    run_to(55);
    bus.din = 16'hBEEF; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    while (cyc < 70) begin
      step();
      if (bus.load_ack) acks++;
    end
    n_checks++;
    if (acks !== 1) begin n_fail++; $display("FAIL ow_ack_count got=%0d exp=1", acks); end
    n_checks++;
    if ({displayD, displayC, displayB, displayA} !== 16'hBEEF) begin
      n_fail++; $display("FAIL ow_display got=%h exp=beef", {displayD, displayC, displayB, displayA});
    end
  endtask

  task automatic test_back_to_back();
    bus.din = 16'h1111; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    run_to(79);
    bus.din = 16'h2222; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    n_checks++;
    if ({displayD, displayC, displayB, displayA} !== 16'h1111) begin
      n_fail++; $display("FAIL b2b_first_commit got=%h exp=1111", {displayD, displayC, displayB, displayA});
    end
    n_checks++;
    if ({bus.load_ack, bus.pending} !== 2'b11) begin
      n_fail++; $display("FAIL b2b_ack_pending got=%b exp=11", {bus.load_ack, bus.pending});
    end
    run_to(95);
    n_checks++;
    if ({displayD, displayC, displayB, displayA, bus.pending} !== {16'h1111, 1'b1}) begin
      n_fail++; $display("FAIL b2b_between disp=%h pend=%b exp=1111/1", {displayD, displayC, displayB, displayA}, bus.pending);
    end
    step();
    n_checks++;
    if ({displayD, displayC, displayB, displayA, bus.load_ack, bus.pending} !== {16'h2222, 2'b10}) begin
      n_fail++; $display("FAIL b2b_second_commit disp=%h ack/pend=%b exp=2222/10", {displayD, displayC, displayB, displayA}, {bus.load_ack, bus.pending});
    end
  endtask

  task automatic test_en_freeze();
    run_to(100);
    bus.din = 16'h3333; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    run_to(105);
    n_checks++;
    if (Select !== 4'b0100) begin n_fail++; $display("FAIL en_pre_select got=%b exp=0100", Select); end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if ({Select, bus.pending, bus.load_ack} !== {4'b0000, 2'b10}) begin
        n_fail++; $display("FAIL en_frozen k=%0d sel=%b pend/ack=%b exp=0000/10", k, Select, {bus.pending, bus.load_ack});
      end
    end
    en = 1'b1;
    step();
    n_checks++;
    if (Select !== 4'b0100) begin n_fail++; $display("FAIL en_resume1 got=%b exp=0100", Select); end
    step();
    n_checks++;
    if (Select !== 4'b0100) begin n_fail++; $display("FAIL en_resume2 got=%b exp=0100", Select); end
    step();
    n_checks++;
    if (Select !== 4'b0000) begin n_fail++; $display("FAIL en_slot_end got=%b exp=0000", Select); end
    run_to(112);
    n_checks++;
    if ({displayD, displayC, displayB, displayA, bus.load_ack} !== {16'h3333, 1'b1}) begin
      n_fail++; $display("FAIL en_late_commit disp=%h ack=%b exp=3333/1", {displayD, displayC, displayB, displayA}, bus.load_ack);
    end
  endtask

  task automatic test_reset_mid_blank();
    int acks;
    acks = 0;
    run_to(114);
    bus.din = 16'h5555; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    n_checks++;
    if ({Select, bus.pending} !== {4'b0000, 1'b1}) begin
      n_fail++; $display("FAIL rb_pre sel=%b pend=%b exp=0000/1", Select, bus.pending);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({Select, displayD, displayC, displayB, displayA} !== {4'b0001, 16'h0000}) begin
      n_fail++; $display("FAIL rb_async sel=%b disp=%h exp=0001/0000", Select, {displayD, displayC, displayB, displayA});
    end
    n_checks++;
    if ({bus.pending, bus.load_ack, frame_start} !== 3'b000) begin
      n_fail++; $display("FAIL rb_flags got=%b exp=000", {bus.pending, bus.load_ack, frame_start});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.load_ack) acks++;
    end
    n_checks++;
    if (acks !== 0) begin n_fail++; $display("FAIL rb_lost_load_ack got=%0d exp=0", acks); end
    n_checks++;
    if ({displayD, displayC, displayB, displayA, bus.pending} !== {16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL rb_after disp=%h pend=%b exp=0000/0", {displayD, displayC, displayB, displayA}, bus.pending);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    test_reset();
    test_scan();
    test_load_commit();
    test_overwrite();
    test_back_to_back();
    test_en_freeze();
    test_reset_mid_blank();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Upstream driver for the four-digit hex-to-seven-segment mux/decoder. It time-multiplexes the display: a prescaler paces a digit-rotation state machine that produces the one-hot Select vector, with a blanking gap between digits to suppress ghosting. It also holds the four 4-bit digit values in display registers that are loaded through a shadow register and a load/ack handshake. The shadow-to-display update happens only at a frame boundary, so a displayed number never tears mid-scan.

Parameters:
PRESCALE, 100000, clock cycles per digit slot (100 MHz gives 1 kHz digit rate, 250 Hz frame rate); must be >= 2.
BLANK, 2, cycles Select is forced to 4'b0000 at the start of each digit slot; must be < PRESCALE.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  scan enable; low freezes scanning and blanks the display.
din  input  16  new digit values: [3:0] to A, [7:4] to B, [11:8] to C, [15:12] to D.
load  input  1  one-cycle strobe; captures din into the shadow register.
displayA  output  4  committed digit A, registered.
displayB  output  4  committed digit B, registered.
displayC  output  4  committed digit C, registered.
displayD  output  4  committed digit D, registered.
Select  output  4  one-hot digit select, registered; 4'b0000 means blank.
frame_start  output  1  one-cycle pulse when the scan index wraps to digit A.
load_ack  output  1  one-cycle pulse in the cycle the shadow value is committed.
pending  output  1  a captured value is waiting for commit.

Behaviour:
- Reset, asynchronous and active-high:
  - prescaler = 0, index = 0, state = DRIVE.
  - Select = 4'b0001.
  - displayA..D = 0, shadow = 0.
  - pending = 0, frame_start = 0, load_ack = 0.
  - Reset asserted mid-operation aborts everything, including a pending load (it is lost).
- Prescaler:
  - Width is $clog2(PRESCALE).
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick = en && prescaler == PRESCALE-1.
  - Holds its value while en = 0.
- Index:
  - 2-bit, mapping 0=A, 1=B, 2=C, 3=D.
  - On tick, index increments and wraps 3 -> 0.
- Select mapping in DRIVE: index 0 -> 4'b0001, 1 -> 4'b0010, 2 -> 4'b0100, 3 -> 4'b1000.
- State machine:
  - DRIVE: Select = one-hot(index). On tick -> BLANK, with blank counter = BLANK-1 and Select = 4'b0000 from the next cycle.
  - BLANK: Select = 4'b0000; counter decrements each cycle; at 0 -> DRIVE, with Select = one-hot(new index) the following cycle.
  - If BLANK = 0, skip the BLANK state; Select switches directly on the cycle after tick.
  - Result: each slot is PRESCALE cycles, of which BLANK are dark.
- en = 0: Select = 4'b0000 from the next cycle, state and index hold, no commits occur. When en returns to 1, Select resumes with one-hot(index) on the next cycle.
- Load and commit:
  - load = 1: shadow <= din, pending <= 1.
  - commit = tick && index == 3 && pending.
  - On commit: displayA..D <= shadow fields, load_ack = 1 for one cycle, pending <= 0.
  - frame_start = 1 for one cycle after every wrapping tick, whether or not a commit occurs. Its cycle aligns with the index = 0 update and with load_ack.
- Simultaneous load and commit in the same cycle: the old shadow is committed, the new din is written to the shadow, and pending stays 1. The new value commits at the next frame boundary.
- Repeated load before commit: the shadow is overwritten, and only the latest value commits. Exactly one load_ack is issued per commit, not per load.
- displayA..D never change except on a commit or a reset.

Test Plan:
- Reset, then scan with PRESCALE=4, BLANK=1, en=1 -> Select sequence per 4-cycle slot: 0001 x3, then 0000, then 0010 x3, 0000, 0100 x3, 0000, 1000 x3, 0000, 0001. frame_start pulses once every 16 cycles.
- load with din=16'h4321 while index=1 -> pending=1 immediately. displayA..D stay 0 until the wrap tick. Then in one cycle A=1, B=2, C=3, D=4, load_ack=1, frame_start=1, pending=0.
- load 16'hAAAA then load 16'hBEEF within the same frame -> a single load_ack, and displays A=F, B=E, C=E, D=B.
- load 16'h1111 committed, then load 16'h2222 asserted exactly on the wrap-tick cycle -> that boundary commits 1111. 2222 commits one frame later, and pending is high in between.
- en=0 during the DRIVE slot of index 2 for 10 cycles -> Select=0000, index and prescaler frozen, a pending load is not committed. After en=1, Select=0100 for the remaining cycles of the slot.
- Assert reset mid-BLANK with pending=1 -> Select=0001, displays 0, pending=0, and no load_ack ever issued for the lost load.
